// File: rtl/dcache_lite_pkg.sv
// Shared types and configuration for the dcache_lite data-side cache.
// Holds the sizing localparams, the controller state enum, the registered
// request payload struct and the address index/tag helpers.
package dcache_lite_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned INDEX_WIDTH  = 8;
    localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned OFFSET_WIDTH = 2;
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned ENTRIES      = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5
    } dcache_state_t;

    typedef struct packed {
        logic                  we;
        logic                  uncached;
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB_WIDTH-1:0] wstrb;
        logic [DATA_WIDTH-1:0] wdata;
    } dcache_req_t;

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/dcache_lite_array.sv
// Storage for dcache_lite: valid vector, tag and data arrays.
// Ports: clk/rst (sync active-high, clears every valid bit in one cycle),
//   index   - entry selected for both read and write
//   we      - byte-enabled data write using wstrb/wdata
//   fill    - also writes wtag and sets the valid bit (used with we)
//   valid_c/tag_c/data_c - combinational read of the selected entry
module dcache_lite_array
    import dcache_lite_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic                   we,
    input  logic                   fill,
    input  logic [STRB_WIDTH-1:0]  wstrb,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [TAG_WIDTH-1:0]   wtag,
    output logic                   valid_c,
    output logic [TAG_WIDTH-1:0]   tag_c,
    output logic [DATA_WIDTH-1:0]  data_c
);

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_mem  [ENTRIES];
    logic [DATA_WIDTH-1:0] data_mem [ENTRIES];

    // Valid bits are the only state that needs reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag on fill, data per byte lane.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[index] <= wtag;
        end
        if (we) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (wstrb[b]) begin
                    data_mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign valid_c = valid_q[index];
    assign tag_c   = tag_mem[index];
    assign data_c  = data_mem[index];

endmodule

// File: rtl/dcache_lite.sv
// Direct-mapped, word-per-entry, write-through, no-write-allocate data cache
// with an uncached bypass, sitting between the mem stage and the bus bridge.
// Ports:
//   clk, rst (sync active-high), flush (cancels a pending load)
//   req_*      - one load/store request, accepted on req_valid & req_ready
//   mem_valid  - mem stage still holds a live instruction
//   data_ok, cache_data_o - single-cycle load completion; data is 0 otherwise
//   rd_*/ret_* - bus read request/grant and data return
//   wr_*       - bus write request/grant/completion
// Optional build macro DCACHE_PERF_CNT_EN adds perf_hit_cnt, perf_miss_cnt and
// perf_uncached_cnt (32-bit wrapping event counters).
module dcache_lite
    import dcache_lite_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_uncached,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  mem_valid,
    output logic                  data_ok,
    output logic [DATA_WIDTH-1:0] cache_data_o,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_rdy,
    input  logic                  ret_valid,
    input  logic [DATA_WIDTH-1:0] ret_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [STRB_WIDTH-1:0] wr_wstrb,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_rdy,
    input  logic                  wr_done
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hit_cnt,
    output logic [31:0]           perf_miss_cnt,
    output logic [31:0]           perf_uncached_cnt
`endif
);

    dcache_state_t state, state_next;
    dcache_req_t   req_q;
    logic          abort_q, abort_next;

    logic                  arr_we, arr_fill;
    logic [STRB_WIDTH-1:0] arr_wstrb;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  arr_valid;
    logic [TAG_WIDTH-1:0]  arr_tag;
    logic [DATA_WIDTH-1:0] arr_data;
    logic                  hit;

    dcache_lite_array u_array (
        .clk     (clk),
        .rst     (rst),
        .index   (addr_index(req_q.addr)),
        .we      (arr_we),
        .fill    (arr_fill),
        .wstrb   (arr_wstrb),
        .wdata   (arr_wdata),
        .wtag    (addr_tag(req_q.addr)),
        .valid_c (arr_valid),
        .tag_c   (arr_tag),
        .data_c  (arr_data)
    );

    assign hit = arr_valid && (arr_tag == addr_tag(req_q.addr));

    // State, abort flag and captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            abort_q <= 1'b0;
            req_q   <= '0;
        end else begin
            state   <= state_next;
            abort_q <= abort_next;
            if (req_valid && req_ready) begin
                req_q <= '{we: req_we, uncached: req_uncached, addr: req_addr,
                           wstrb: req_wstrb, wdata: req_wdata};
            end
        end
    end

    // Next state, bus handshakes, array writes and the load response.
    // Everything is held at 0 while rst is asserted.
    always_comb begin
        state_next   = state;
        abort_next   = abort_q;
        req_ready    = 1'b0;
        data_ok      = 1'b0;
        cache_data_o = '0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_wstrb     = '0;
        wr_data      = '0;
        arr_we       = 1'b0;
        arr_fill     = 1'b0;
        arr_wstrb    = '0;
        arr_wdata    = '0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    req_ready = !flush;
                    if (req_valid && !flush) begin
                        state_next = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        state_next = IDLE;
                    end else if (req_q.we) begin
                        // Write-through: update only an existing cached copy.
                        if (!req_q.uncached && hit) begin
                            arr_we    = 1'b1;
                            arr_wstrb = req_q.wstrb;
                            arr_wdata = req_q.wdata;
                        end
                        state_next = WR_REQ;
                    end else if (!req_q.uncached && hit) begin
                        data_ok      = mem_valid;
                        cache_data_o = mem_valid ? arr_data : '0;
                        state_next   = IDLE;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
                RD_REQ: begin
                    rd_req  = 1'b1;
                    rd_addr = {req_q.addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                    if (rd_rdy) begin
                        // Granted read must drain even if the load is flushed.
                        abort_next = abort_q | flush;
                        state_next = RD_WAIT;
                    end else if (flush) begin
                        state_next = IDLE;
                    end
                end
                RD_WAIT: begin
                    if (flush) begin
                        abort_next = 1'b1;
                    end
                    if (ret_valid) begin
                        abort_next = 1'b0;
                        state_next = IDLE;
                        if (!abort_q && !flush) begin
                            data_ok      = mem_valid;
                            cache_data_o = mem_valid ? ret_data : '0;
                            if (!req_q.uncached) begin
                                arr_we    = 1'b1;
                                arr_fill  = 1'b1;
                                arr_wstrb = '1;
                                arr_wdata = ret_data;
                            end
                        end
                    end
                end
                WR_REQ: begin
                    wr_req   = 1'b1;
                    wr_addr  = req_q.addr;
                    wr_wstrb = req_q.wstrb;
                    wr_data  = req_q.wdata;
                    if (wr_rdy) begin
                        state_next = WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wr_done) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic hit_ev, miss_ev, unc_ev;

    // Hit counts whether or not the load is flushed; misses count on entry to RD_REQ.
    assign hit_ev  = (state == LOOKUP) && !req_q.we && !req_q.uncached && hit;
    assign miss_ev = (state == LOOKUP) && !flush && !req_q.we && !req_q.uncached && !hit;
    assign unc_ev  = (state == LOOKUP) && !flush && !req_q.we && req_q.uncached;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_cnt      <= '0;
            perf_miss_cnt     <= '0;
            perf_uncached_cnt <= '0;
        end else begin
            if (hit_ev)  perf_hit_cnt      <= perf_hit_cnt + 32'd1;
            if (miss_ev) perf_miss_cnt     <= perf_miss_cnt + 32'd1;
            if (unc_ev)  perf_uncached_cnt <= perf_uncached_cnt + 32'd1;
        end
    end
`endif

endmodule
